// File: rtl/spi_ram_burst_slave.sv
// SPI slave with a single-port RAM, independent write/read pointers and abort detection.
// MISO shows word MSB after edge 4 of a read frame; define SPI_RAM_BURST_EN for auto-increment bursts.
module spi_ram_burst_slave #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int SW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int SHW = SW - 1;
  localparam int CW  = $clog2(SW + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RTURN, RDATA} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SHW-1:0]      shift_q, shift_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                tgt_rd_q, tgt_rd_d, hold_q, hold_d;
  logic                miso_q, miso_d, ferr_q, ferr_d;
  logic [DATA_W-1:0]   oshift_q, oshift_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata_q, word;
  logic [ADDR_W-1:0]   addr_in, re_addr;
  logic                we, re;

  function automatic logic [ADDR_W-1:0] inc_ptr(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tgt_rd_q <= 1'b0;
      hold_q   <= 1'b0;
      miso_q   <= 1'b0;
      ferr_q   <= 1'b0;
      oshift_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tgt_rd_q <= tgt_rd_d;
      hold_q   <= hold_d;
      miso_q   <= miso_d;
      ferr_q   <= ferr_d;
      oshift_q <= oshift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = CMD;
        CMD: begin
          case ({shift_q[0], MOSI})
            2'b00, 2'b10: state_d = ADDR;
            2'b01:        state_d = WDATA;
            default:      state_d = RTURN;
          endcase
        end
        RTURN: if (cnt_q != '0) state_d = RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tgt_rd_d = tgt_rd_q;
    hold_d   = hold_q;
    miso_d   = 1'b0;
    oshift_d = oshift_q;
    we       = 1'b0;
    re       = 1'b0;
    re_addr  = rd_ptr_q;
    word     = {shift_q[DATA_W-2:0], MOSI};
    addr_in  = {shift_q[ADDR_W-2:0], MOSI};
    // Abort is only an error when a field was partially shifted in.
    ferr_d   = SS_n && ((state_q == CMD) ||
                        (((state_q == ADDR) || (state_q == WDATA)) && (cnt_q != '0)));
    if (SS_n) begin
      cnt_d  = '0;
      hold_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          shift_d = SHW'({shift_q, MOSI});
          cnt_d   = '0;
          hold_d  = 1'b0;
        end
        CMD: begin
          tgt_rd_d = shift_q[0];
          cnt_d    = '0;
          re       = (shift_q[0] && MOSI);
        end
        ADDR: if (!hold_q) begin
          shift_d = SHW'({shift_q, MOSI});
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(ADDR_W - 1)) begin
            cnt_d  = '0;
            hold_d = 1'b1;
            if (tgt_rd_q) rd_ptr_d = ADDR_W'(int'(addr_in) % DEPTH);
            else          wr_ptr_d = ADDR_W'(int'(addr_in) % DEPTH);
          end
        end
        WDATA: if (!hold_q) begin
          shift_d = SHW'({shift_q, MOSI});
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) begin
            we    = 1'b1;
            cnt_d = '0;
`ifdef SPI_RAM_BURST_EN
            wr_ptr_d = inc_ptr(wr_ptr_q);
`else
            hold_d = 1'b1;
`endif
          end
        end
        RTURN: begin
          cnt_d = CW'(1);
          if (cnt_q != '0) begin
            miso_d   = rdata_q[DATA_W-1];
            oshift_d = rdata_q;
          end
        end
        RDATA: if (!hold_q) begin
          if (cnt_q == CW'(DATA_W)) begin
`ifdef SPI_RAM_BURST_EN
            miso_d   = rdata_q[DATA_W-1];
            oshift_d = rdata_q;
            cnt_d    = CW'(1);
`else
            hold_d = 1'b1;
            cnt_d  = '0;
`endif
          end else begin
            miso_d   = oshift_q[DATA_W-2];
            oshift_d = oshift_q << 1;
            cnt_d    = cnt_q + 1'b1;
`ifdef SPI_RAM_BURST_EN
            // Prefetch the next word while bit 1 goes out so words abut.
            if (cnt_q == CW'(DATA_W - 2)) begin
              re       = 1'b1;
              re_addr  = inc_ptr(rd_ptr_q);
              rd_ptr_d = inc_ptr(rd_ptr_q);
            end
`endif
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we) mem[wr_ptr_q] <= word;
    if (re) rdata_q <= mem[re_addr];
  end

  always_comb begin
    MISO      = miso_q;
    busy      = (state_q != IDLE);
    frame_err = ferr_q;
  end

endmodule

// File: doc/spi_ram_burst_slave.md
Name: spi_ram_burst_slave

Overview:
- Parametrised successor of the SPI-slave-plus-single-port-RAM block.
- Single clock domain: the SPI bit clock is `clk`; MOSI is sampled and MISO is updated on `posedge clk` while SS_n is low.
- Adds generic data width and depth, independent write and read pointers, and auto-incrementing burst reads and writes with pointer wrap.
- Adds aborted-frame detection.

Parameters:
- DATA_W, 8: RAM word width and bits per data word on the wire.
- DEPTH, 256: number of RAM words.
- ADDR_W, 8: address field width on the wire and pointer width; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system/SPI clock, rising-edge active.
- rst_n  in  1  reset; asynchronous, active-low.
- SS_n  in  1  slave select, active-low, frames a transaction.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first; driven 0 outside the read-data phase.
- busy  out  1  high whenever state != IDLE.
- frame_err  out  1  one-cycle pulse when a frame is aborted mid-field.

Behaviour:
- Clock and reset: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE; wr_ptr = rd_ptr = 0; bit counter = 0; MISO = 0; busy = 0; frame_err = 0.
  - RAM contents are not reset.
- Edge numbering: edge k (k = 1, 2, …) is the k-th posedge with SS_n low since SS_n fell. Each edge shifts one MOSI bit into the shift register.
- States: IDLE, CMD, ADDR, WDATA, RTURN, RDATA.
- IDLE -> CMD: at the first edge with SS_n low; that edge samples command bit 1.
- CMD: edge 2 samples command bit 0. Decode {b1,b0}:
  - 00 WR_ADDR -> ADDR, target wr_ptr.
  - 10 RD_ADDR -> ADDR, target rd_ptr.
  - 01 WR_DATA -> WDATA.
  - 11 RD_DATA -> RTURN; the RAM read of mem[rd_ptr] is issued on this edge.
- ADDR:
  - Shifts ADDR_W bits. On the edge sampling the last bit, loads the target pointer with {shift, MOSI}.
  - Values >= DEPTH are loaded modulo DEPTH.
  - Then waits in ADDR, ignoring MOSI, until SS_n rises.
- WDATA:
  - Shifts DATA_W bits. On the edge sampling bit 0, writes mem[wr_ptr] <= {shift, MOSI} and increments wr_ptr.
  - Stays in WDATA for the next word (burst).
- RTURN:
  - Lasts one edge (edge 3) while the registered RAM read completes.
  - Edge 4 enters RDATA and drives MISO = word[DATA_W-1].
- RDATA:
  - MISO shifts one bit per edge.
  - Word n, bit i is valid after edge 4 + n*DATA_W + (DATA_W-1-i).
  - The RAM read for the next word is issued one edge before the current word's bit 0 is driven, with rd_ptr incremented at the same time. Output is gapless across words.
  - MOSI is ignored.
- Pointer wrap: when a pointer at DEPTH-1 increments, it becomes 0.
- SS_n high:
  - From any state, at the next edge go to IDLE, clear the bit counter, set MISO = 0, and discard any partial ADDR/WDATA word.
  - Pointers keep their last committed values.
- frame_err:
  - Pulses high for exactly one cycle at the edge SS_n is seen high if the state was CMD, or was ADDR/WDATA with a nonzero bit count.
  - No pulse when leaving RDATA, RTURN, or a word-aligned WDATA/ADDR.
- Simultaneous events:
  - A write and a read to the same address cannot coincide; one frame carries one command.
  - Reset asserted mid-frame: immediate return to reset values; a write in flight on that edge does not occur.
- A new frame requires SS_n high for at least one edge.

Optional Feature:
- Macro: SPI_RAM_BURST_EN.
- Defined: burst behaviour as above; pointers auto-increment after each word.
- Undefined:
  - One data word per frame.
  - wr_ptr and rd_ptr never auto-increment.
  - After the first WDATA word, or after the first RDATA word's bit 0, the state holds and ignores MOSI. MISO = 0 until SS_n rises.
  - No frame_err pulse for extra bits.

Test Plan:
- Use DATA_W=8, DEPTH=256 throughout.
- Reset mid-RDATA (rst_n low 1 cycle) -> MISO = 0, busy = 0, rd_ptr = 0 immediately, without waiting for a clock edge.
- WR_ADDR 0x05, then WR_DATA burst 0xA1, 0xB2, 0xC3 -> mem[5..7] = A1, B2, C3; wr_ptr = 0x08; frame_err never pulses.
- RD_ADDR 0x05, then RD_DATA for 24 bits -> MISO bit stream A1 B2 C3, with the MSB of A1 after edge 4 and no gaps; rd_ptr = 0x08.
- WR_ADDR 0xFF, then WR_DATA 0x11, 0x22 -> mem[255] = 0x11, mem[0] = 0x22, wr_ptr = 0x01 (wrap).
- WR_DATA frame with SS_n raised after 5 data bits -> no RAM write, wr_ptr unchanged, frame_err high exactly one cycle.
- Build without SPI_RAM_BURST_EN and repeat the 3-word write at 0x05 -> only mem[5] = A1; mem[6], mem[7] unchanged; wr_ptr = 0x05.
